// File: rtl/neuron_mac_if.sv
// Valid/ready bundle between the operand source, the neuron MAC and the
// sigmoid LUT that consumes z_out.
interface neuron_mac_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [15:0] w_in;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z_out;
    logic        sat;

    // Upstream/downstream environment side: drives operands and out_ready.
    modport master (
        output in_valid, x_in, w_in, bias, out_ready,
        input  in_ready, out_valid, z_out, sat
    );

    // Neuron MAC side.
    modport slave (
        input  in_valid, x_in, w_in, bias, out_ready,
        output in_ready, out_valid, z_out, sat
    );
endinterface

// File: rtl/neuron_mac.sv
// Serial multiply-accumulate for one neuron: z = bias + sum(x*w) over
// N_INPUTS Q4.12 pairs, rounded and saturated back to Q4.12 for the sigmoid.
module neuron_mac #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 40
) (
    input  logic         clk,
    input  logic         rst,
    neuron_mac_if.slave  bus
);

    localparam int CNT_W = (N_INPUTS < 2) ? 1 : $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(2048);
    localparam logic signed [ACC_W-1:0] Q_MAX    = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] Q_MIN    = -ACC_W'(32768);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        HOLD
    } state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [15:0]              z_q, z_d;
    logic                     sat_q, sat_d;

    logic                     in_ready;
    logic                     beat;
    logic signed [31:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_rnd;
    logic signed [ACC_W-1:0]  r;

    assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
    assign beat     = bus.in_valid & in_ready;

    // Q4.12 * Q4.12 is exact in Q8.24; bias is lifted to the same scale.
    assign prod     = $signed(bus.x_in) * $signed(bus.w_in);
    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
    assign bias_ext = {{(ACC_W-28){bus.bias[15]}}, bus.bias, 12'b0};

    assign acc_rnd  = acc_q + HALF_LSB;
    assign r        = acc_rnd >>> 12;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        z_d         = z_q;
        sat_d       = sat_q;

        unique case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_d   = bias_ext + prod_ext;
                    cnt_d   = CNT_W'(1);
                    state_d = (N_INPUTS == 1) ? ROUND : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ROUND;
                    end
                end
            end
            ROUND: begin
                if (r > Q_MAX) begin
                    z_d   = 16'h7FFF;
                    sat_d = 1'b1;
                end else if (r < Q_MIN) begin
                    z_d   = 16'h8000;
                    sat_d = 1'b1;
                end else begin
                    z_d   = r[15:0];
                    sat_d = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.z_out     = z_q;
    assign bus.sat       = sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: hand-computed Q4.12 results, stalls, gaps,
// saturation, rounding and mid-stream reset.
module tb_neuron_mac;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    neuron_mac_if bus ();

    neuron_mac #(.N_INPUTS(4), .ACC_W(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one beat at a negedge; it is taken at the following posedge.
    task automatic send(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b,
                        input bit gap);
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        bus.w_in     = w;
        bus.bias     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    // Four beats; later beats carry a junk bias that must be ignored.
    task automatic run_neuron(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b,
                              input bit gap);
        send(x, w, b, gap);
        for (int i = 1; i < 4; i++) send(x, w, 16'h7000, gap);
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {15'b0, bus.out_valid}, 16'h0001);
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_ov_drop"}, {15'b0, bus.out_valid}, 16'h0000);
        check({tag, "_rdy_back"}, {15'b0, bus.in_ready}, 16'h0001);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.w_in      = '0;
        bus.bias      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {15'b0, bus.in_ready}, 16'h0001);
        check("rst_out_valid", {15'b0, bus.out_valid}, 16'h0000);
        check("rst_z", bus.z_out, 16'h0000);
        check("rst_sat", {15'b0, bus.sat}, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // 1: 4 x 0.5 = 2.0, back-to-back; ROUND cycle then valid
        run_neuron(16'h1000, 16'h0800, 16'h0000, 1'b0);
        check("t1_lat_k", {15'b0, bus.out_valid}, 16'h0000);
        check("t1_round_rdy", {15'b0, bus.in_ready}, 16'h0000);
        @(negedge clk);
        check("t1_lat_k1", {15'b0, bus.out_valid}, 16'h0001);
        check("t1_z", bus.z_out, 16'h2000);
        check("t1_sat", {15'b0, bus.sat}, 16'h0000);
        consume("t1");

        // 2a: positive overflow
        run_neuron(16'h7000, 16'h7000, 16'h0000, 1'b0);
        wait_result("t2a");
        check("t2a_z", bus.z_out, 16'h7FFF);
        check("t2a_sat", {15'b0, bus.sat}, 16'h0001);
        consume("t2a");

        // 2b: 4*(-2.0) + (-0.5) = -8.5 -> negative clamp
        run_neuron(16'hF000, 16'h2000, 16'hF800, 1'b0);
        wait_result("t2b");
        check("t2b_z", bus.z_out, 16'h8000);
        check("t2b_sat", {15'b0, bus.sat}, 16'h0001);
        consume("t2b");

        // 3: exactly half an LSB rounds up, minus half rounds to zero
        run_neuron(16'h0001, 16'h0200, 16'h0000, 1'b0);
        wait_result("t3a");
        check("t3a_z", bus.z_out, 16'h0001);
        check("t3a_sat", {15'b0, bus.sat}, 16'h0000);
        consume("t3a");
        run_neuron(16'hFFFF, 16'h0200, 16'h0000, 1'b0);
        wait_result("t3b");
        check("t3b_z", bus.z_out, 16'h0000);
        consume("t3b");

        // 4: stall in HOLD with in_valid pushing beats that must be ignored
        run_neuron(16'h1000, 16'h0800, 16'h0000, 1'b0);
        wait_result("t4");
        bus.in_valid = 1'b1;
        bus.x_in     = 16'h7FFF;
        bus.w_in     = 16'h7FFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_z", bus.z_out, 16'h2000);
            check("t4_hold_sat", {15'b0, bus.sat}, 16'h0000);
            check("t4_hold_rdy", {15'b0, bus.in_ready}, 16'h0000);
            check("t4_hold_ov", {15'b0, bus.out_valid}, 16'h0001);
        end
        bus.in_valid = 1'b0;
        consume("t4");
        run_neuron(16'h1000, 16'h0800, 16'h0000, 1'b0);
        wait_result("t4_after");
        check("t4_after_z", bus.z_out, 16'h2000);
        consume("t4_after");

        // 5: one idle cycle between every beat
        run_neuron(16'h1000, 16'h0800, 16'h0000, 1'b1);
        wait_result("t5");
        check("t5_z", bus.z_out, 16'h2000);
        check("t5_sat", {15'b0, bus.sat}, 16'h0000);
        consume("t5");

        // 6: reset after two beats, then a clean neuron
        send(16'h7000, 16'h7000, 16'h4000, 1'b0);
        send(16'h7000, 16'h7000, 16'h4000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_rdy", {15'b0, bus.in_ready}, 16'h0001);
        check("t6_rst_ov", {15'b0, bus.out_valid}, 16'h0000);
        run_neuron(16'h1000, 16'h0800, 16'h0000, 1'b0);
        wait_result("t6");
        check("t6_z", bus.z_out, 16'h2000);
        check("t6_sat", {15'b0, bus.sat}, 16'h0000);

        // Reset while a saturated result sits in HOLD
        consume("t6");
        run_neuron(16'h7000, 16'h7000, 16'h0000, 1'b0);
        wait_result("t7");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t7_rst_ov", {15'b0, bus.out_valid}, 16'h0000);
        check("t7_rst_z", bus.z_out, 16'h0000);
        check("t7_rst_sat", {15'b0, bus.sat}, 16'h0000);
        check("t7_rst_rdy", {15'b0, bus.in_ready}, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
